// File: rtl/fps_report_pkg.sv
// Shared constants, state encodings and helpers for the FPS UART reporter.
package fps_report_pkg;

    localparam int unsigned MSG_LEN = 8;

    localparam logic [7:0] ASCII_F   = 8'h46;
    localparam logic [7:0] ASCII_P   = 8'h50;
    localparam logic [7:0] ASCII_S   = 8'h53;
    localparam logic [7:0] ASCII_EQ  = 8'h3D;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_Q   = 8'h3F;

    typedef logic [2:0] state_t;

    // Bit-phase states of the byte serialiser
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;

    // Message-level states of the sequencer
    localparam state_t MSG_IDLE = 3'd4;
    localparam state_t MSG_SEND = 3'd5;
    localparam state_t MSG_DONE = 3'd6;

    // BCD digit to ASCII; anything above 9 becomes '?'
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_Q : (ASCII_0 + {4'h0, d});
    endfunction

endpackage

// File: rtl/fps_uart_tx_byte.sv
// 8N1 byte serialiser; accepts a new byte on the last stop-bit cycle so
// consecutive bytes go out with no idle gap.
module uart_tx_byte
    import fps_report_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       bit_n, bit_n_d;
    logic [9:0]       frame, frame_d;
    logic             tx_d, ready_d, done_d;
    logic             bit_end_c, load_c;

    // Next-state logic: bit timing, frame shifting and back-to-back reload
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_n_d   = bit_n;
        frame_d   = frame;
        tx_d      = tx;
        bit_end_c = (cnt == CNT_LAST);
        load_c    = start && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end_c));

        case (state)
            ST_START, ST_DATA: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    frame_d = {1'b1, frame[9:1]};
                    tx_d    = frame[1];
                    bit_n_d = bit_n + 4'd1;
                    state_d = (bit_n == 4'd8) ? ST_STOP : ST_DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            state_d = ST_START;
            frame_d = {1'b1, data, 1'b0};
            tx_d    = 1'b0;
            cnt_d   = '0;
            bit_n_d = 4'd0;
        end

        done_d  = (state == ST_STOP) && (cnt == CNT_PRE);
        ready_d = (state_d == ST_IDLE) || ((state_d == ST_STOP) && (cnt_d == CNT_LAST));
    end

    // Serialiser registers; tx comes straight from a flop
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bit_n <= 4'd0;
            frame <= '1;
            tx    <= 1'b1;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            bit_n <= bit_n_d;
            frame <= frame_d;
            tx    <= tx_d;
            ready <= ready_d;
            done  <= done_d;
        end
    end

endmodule

// File: rtl/fps_uart_reporter.sv
// Sends "FPS=<tens><units>\r\n" over UART whenever the BCD reading changes.
module fps_uart_reporter
    import fps_report_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [3:0]  fps_h,
    input  logic [3:0]  fps_l,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] msg_count
);

    state_t     state, state_d;
    logic [2:0] idx;
    logic [7:0] snap, last_sent;
    logic       start_c, trigger_c;
    logic [2:0] sel_c;
    logic [7:0] data_c;
    logic       tx_ready, tx_done;

    function automatic logic [7:0] msg_byte(input logic [2:0] sel, input logic [7:0] s);
        case (sel)
            3'd0:    return ASCII_F;
            3'd1:    return ASCII_P;
            3'd2:    return ASCII_S;
            3'd3:    return ASCII_EQ;
            3'd4:    return bcd_to_ascii(s[7:4]);
            3'd5:    return bcd_to_ascii(s[3:0]);
            3'd6:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    assign trigger_c = enable && ({fps_h, fps_l} != last_sent) && tx_ready;

    // Message sequencing: launch byte 0 on trigger, chain bytes on each done
    always_comb begin
        state_d = state;
        start_c = 1'b0;
        sel_c   = 3'd0;
        case (state)
            MSG_IDLE: begin
                if (trigger_c) begin
                    start_c = 1'b1;
                    state_d = MSG_SEND;
                end
            end
            MSG_SEND: begin
                if (tx_done) begin
                    if (idx != 3'(MSG_LEN - 1)) begin
                        start_c = 1'b1;
                        sel_c   = idx + 3'd1;
                    end else begin
                        state_d = MSG_DONE;
                    end
                end
            end
            MSG_DONE: state_d = MSG_IDLE;
            default:  state_d = MSG_IDLE;
        endcase
        data_c = msg_byte(sel_c, snap);
    end

    // State register
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) state <= MSG_IDLE;
        else          state <= state_d;
    end

    // Snapshot, byte index, busy flag, last reported value and message counter
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            snap      <= 8'h00;
            idx       <= 3'd0;
            busy      <= 1'b0;
            last_sent <= 8'hFF;
            msg_count <= 16'd0;
        end else begin
            if ((state == MSG_IDLE) && start_c) begin
                snap <= {fps_h, fps_l};
                idx  <= 3'd0;
                busy <= 1'b1;
            end else if ((state == MSG_SEND) && start_c) begin
                idx <= idx + 3'd1;
            end
            if (state == MSG_DONE) begin
                last_sent <= snap;
                msg_count <= msg_count + 16'd1;
                busy      <= 1'b0;
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk50   (clk50),
        .reset_n (reset_n),
        .start   (start_c),
        .data    (data_c),
        .tx      (uart_tx),
        .ready   (tx_ready),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_fps_uart_reporter.sv
// Directed bench for fps_uart_reporter, run with a 4-clock bit period.
module tb_fps_uart_reporter;

    localparam int unsigned CPB = 4;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  fps_h = 4'd0;
    logic [3:0]  fps_l = 4'd0;
    logic        uart_tx;
    logic        busy;
    logic [15:0] msg_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned busy_total = 0;
    int unsigned snap0;
    int          lows;
    logic [7:0]  rx [8];

    fps_uart_reporter #(.CLK_HZ(1_000_000), .BAUD(250_000)) dut (
        .clk50     (clk50),
        .reset_n   (reset_n),
        .enable    (enable),
        .fps_h     (fps_h),
        .fps_l     (fps_l),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .msg_count (msg_count)
    );

    always #5 clk50 = ~clk50;

    always @(negedge clk50) if (busy) busy_total <= busy_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decode one frame starting at the current sample; every bit must hold for CPB samples
    task automatic recv_byte(input string tag, output logic [7:0] b);
        logic [9:0] fr;
        logic       bad;
        bad = 1'b0;
        fr  = '0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk50);
                if (c == 0) fr[k] = uart_tx;
                else if (uart_tx !== fr[k]) bad = 1'b1;
            end
        end
        @(negedge clk50);
        chk({tag, "_frame"}, {29'd0, bad, fr[0], fr[9]}, 32'b001);
        b = fr[8:1];
    endtask

    task automatic recv_msg(input string tag, input int upto);
        for (int i = 0; i < upto; i++) begin
            logic [7:0] b;
            recv_byte(tag, b);
            rx[i] = b;
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] eh, input logic [7:0] el);
        chk({tag, "_b0"}, {24'd0, rx[0]}, 32'h46);
        chk({tag, "_b1"}, {24'd0, rx[1]}, 32'h50);
        chk({tag, "_b2"}, {24'd0, rx[2]}, 32'h53);
        chk({tag, "_b3"}, {24'd0, rx[3]}, 32'h3D);
        chk({tag, "_b4"}, {24'd0, rx[4]}, {24'd0, eh});
        chk({tag, "_b5"}, {24'd0, rx[5]}, {24'd0, el});
        chk({tag, "_b6"}, {24'd0, rx[6]}, 32'h0D);
        chk({tag, "_b7"}, {24'd0, rx[7]}, 32'h0A);
    endtask

    initial begin
        // Reset with arbitrary inputs
        enable = 1'b1; fps_h = 4'd7; fps_l = 4'd7;
        repeat (3) @(negedge clk50);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, msg_count}, 32'd0);
        enable = 1'b0;
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk50);
            if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("disabled_idle", lows, 0);

        // First message 3/0
        fps_h = 4'd3; fps_l = 4'd0; enable = 1'b1;
        snap0 = busy_total;
        @(negedge clk50);
        chk("m1_start_tx", {31'd0, uart_tx}, 32'd0);
        chk("m1_start_busy", {31'd0, busy}, 32'd1);
        recv_msg("m1", 8);
        check_bytes("m1", 8'h33, 8'h30);
        chk("m1_done_tx", {31'd0, uart_tx}, 32'd1);
        chk("m1_done_busy", {31'd0, busy}, 32'd1);
        @(negedge clk50);
        chk("m1_busy_fall", {31'd0, busy}, 32'd0);
        chk("m1_busy_len", busy_total - snap0, 80 * CPB + 1);
        chk("m1_count", {16'd0, msg_count}, 32'd1);

        // Same value held: nothing more is sent
        lows = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk50);
            if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("no_repeat", lows, 0);
        chk("no_repeat_cnt", {16'd0, msg_count}, 32'd1);

        // Message with 1/7, inputs switch to 2/9 during byte index 2
        fps_h = 4'd1; fps_l = 4'd7;
        @(negedge clk50);
        recv_msg("m2", 2);
        fps_h = 4'd2; fps_l = 4'd9;
        for (int i = 2; i < 8; i++) begin
            logic [7:0] b;
            recv_byte("m2", b);
            rx[i] = b;
        end
        check_bytes("m2", 8'h31, 8'h37);
        chk("m2_done_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk50);
        chk("m2_idle_tx", {31'd0, uart_tx}, 32'd1);
        chk("m2_idle_busy", {31'd0, busy}, 32'd0);
        chk("m2_count", {16'd0, msg_count}, 32'd2);
        @(negedge clk50);
        chk("m3_start_tx", {31'd0, uart_tx}, 32'd0);
        chk("m3_start_busy", {31'd0, busy}, 32'd1);
        recv_msg("m3", 8);
        check_bytes("m3", 8'h32, 8'h39);
        @(negedge clk50);
        chk("m3_count", {16'd0, msg_count}, 32'd3);

        // Invalid tens digit
        fps_h = 4'hA; fps_l = 4'd5;
        @(negedge clk50);
        recv_msg("m4", 8);
        check_bytes("m4", 8'h3F, 8'h35);
        @(negedge clk50);
        chk("m4_count", {16'd0, msg_count}, 32'd4);

        // Reset in the middle of byte index 4, then full resend of same value
        fps_h = 4'd6; fps_l = 4'd1;
        @(negedge clk50);
        recv_msg("m5", 4);
        @(negedge clk50);
        chk("m5_pre_rst_tx", {31'd0, uart_tx}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("m5_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("m5_rst_busy", {31'd0, busy}, 32'd0);
        chk("m5_rst_cnt", {16'd0, msg_count}, 32'd0);
        @(negedge clk50);
        reset_n = 1'b1;
        @(negedge clk50);
        chk("m6_start_busy", {31'd0, busy}, 32'd1);
        recv_msg("m6", 8);
        check_bytes("m6", 8'h36, 8'h31);
        @(negedge clk50);
        chk("m6_count", {16'd0, msg_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
